// File: rtl/fifo_fwft_ctrl.sv
// First-word-fall-through FIFO controller around a 1-cycle registered-read memory.
// A 2-entry output queue absorbs the read latency so valid/ready runs at one word per cycle.
module fifo_fwft_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int AF_MARGIN  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH+1:0] level,
   output logic                  overflow,
   input  logic                  clr_err,
   output logic                  mem_w_en,
   output logic [ADDR_WIDTH-1:0] mem_w_addr,
   output logic [DATA_WIDTH-1:0] mem_w_data,
   output logic                  mem_r_en,
   output logic [ADDR_WIDTH-1:0] mem_r_addr,
   input  logic [DATA_WIDTH-1:0] mem_r_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   mem_cnt;
   logic                  rd_inflight;
   logic [1:0]            ob_cnt;
   logic [DATA_WIDTH-1:0] ob_head;
   logic [DATA_WIDTH-1:0] ob_tail;
   logic [2:0]            pending;
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  capture;

   assign mem_cnt     = wr_ptr - rd_ptr;
   assign full        = (mem_cnt == (ADDR_WIDTH+1)'(DEPTH));
   assign almost_full = (mem_cnt >= (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN));

   assign m_valid = (ob_cnt != 2'd0);
   assign m_data  = m_valid ? ob_head : '0;
   assign pop     = m_valid & m_ready;

   // Words already committed to the output queue after this cycle's pop.
   assign pending = {1'b0, ob_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
   assign push    = wr_en & ~full & ~flush;
   assign issue   = ~flush & (mem_cnt != '0) & (pending < 3'd2);
   assign capture = rd_inflight;

   assign mem_w_en   = push;
   assign mem_w_addr = wr_ptr[ADDR_WIDTH-1:0];
   assign mem_w_data = wr_data;
   assign mem_r_en   = issue;
   assign mem_r_addr = rd_ptr[ADDR_WIDTH-1:0];

   assign level = {1'b0, mem_cnt}
                + {{(ADDR_WIDTH+1){1'b0}}, rd_inflight}
                + {{ADDR_WIDTH{1'b0}}, ob_cnt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rd_inflight <= 1'b0;
         ob_cnt      <= 2'd0;
      end else if (flush) begin
         // Clearing rd_inflight also drops the read word returning next cycle.
         rd_ptr      <= wr_ptr;
         rd_inflight <= 1'b0;
         ob_cnt      <= 2'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
         if (issue)
            rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
         rd_inflight <= issue;
         ob_cnt      <= ob_cnt + {1'b0, capture} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (wr_en && full)
         overflow <= 1'b1;
      else if (clr_err)
         overflow <= 1'b0;
   end

   // Output queue storage; contents are don't-care whenever ob_cnt says empty.
   always_ff @(posedge clk) begin
      case ({capture, pop})
         2'b10: begin
            if (ob_cnt == 2'd0)
               ob_head <= mem_r_data;
            else
               ob_tail <= mem_r_data;
         end
         2'b01: ob_head <= ob_tail;
         2'b11: begin
            if (ob_cnt == 2'd1)
               ob_head <= mem_r_data;
            else begin
               ob_head <= ob_tail;
               ob_tail <= mem_r_data;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      if (mem_w_en && mem_r_en && (mem_w_addr == mem_r_addr))
         assert (mem_cnt == (ADDR_WIDTH+1)'(DEPTH));
   end

endmodule

// File: tb/tb_fifo_fwft_ctrl.sv
// Directed bench for fifo_fwft_ctrl with a behavioural registered-read memory attached.
module tb_fifo_fwft_ctrl;

   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          m_ready = 1'b0;
   logic          clr_err = 1'b0;
   logic          full, almost_full, m_valid, overflow, mem_w_en, mem_r_en;
   logic [DW-1:0] m_data, mem_w_data;
   logic [DW-1:0] mem_r_data = '0;
   logic [AW+1:0] level;
   logic [AW-1:0] mem_w_addr, mem_r_addr;
   logic [DW-1:0] mem [DEPTH];

   int checks = 0;
   int errors = 0;

   fifo_fwft_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_MARGIN(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .almost_full(almost_full), .m_valid(m_valid), .m_data(m_data),
      .m_ready(m_ready), .level(level), .overflow(overflow), .clr_err(clr_err),
      .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
      .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
      if (mem_r_en) mem_r_data <= mem[mem_r_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b want 0", almost_full); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", m_data); end
      checks++; if ({mem_w_en, mem_r_en, overflow} !== 3'b000) begin errors++; $display("FAIL reset_en_ovf got %b want 000", {mem_w_en, mem_r_en, overflow}); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL lat_level_c1 got %0d want 1", level); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_c1 got %b want 0", m_valid); end
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_c2 got %b want 0", m_valid); end
      tick();
      checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin errors++; $display("FAIL lat_valid_c3 got %b/%h want 1/a5", m_valid, m_data); end
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL lat_level_c3 got %0d want 1", level); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL lat_pop got %b/%0d want 0/0", m_valid, level); end
   endtask

   task automatic test_fill();
      m_ready = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         wr_en = 1'b1; wr_data = DW'(i);
         @(negedge clk);
         if (i == 9) begin
            checks++; if (full !== 1'b0 || almost_full !== 1'b1 || level !== 5'd9) begin errors++; $display("FAIL fill_c9 got full=%b af=%b lvl=%0d want 0 1 9", full, almost_full, level); end
         end
         if (i == 10) begin
            checks++; if (full !== 1'b1 || level !== 5'd10) begin errors++; $display("FAIL fill_full got full=%b lvl=%0d want 1 10", full, level); end
            checks++; if (mem_w_en !== 1'b0) begin errors++; $display("FAIL fill_drop got w_en=%b want 0", mem_w_en); end
         end
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b want 1", overflow); end
      checks++; if (level !== 5'd10 || m_valid !== 1'b1 || m_data !== 8'h00) begin errors++; $display("FAIL fill_head got lvl=%0d v=%b d=%h want 10 1 00", level, m_valid, m_data); end
   endtask

   task automatic test_stream();
      int nxt_wr = 10;
      int exp_rd = 0;
      m_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         wr_en = 1'b1; wr_data = DW'(nxt_wr);
         @(negedge clk);
         checks++;
         if (m_valid !== 1'b1 || m_data !== DW'(exp_rd)) begin
            errors++; $display("FAIL stream_pop c=%0d got %b/%h want 1/%h", c, m_valid, m_data, DW'(exp_rd));
         end
         exp_rd++;
         if (!full) nxt_wr++;
         @(posedge clk); #1;
      end
      checks++; if (nxt_wr !== 29) begin errors++; $display("FAIL stream_accepts got %0d want 29", nxt_wr); end
      wr_en = 1'b0;
      for (int c = 0; c < 40 && exp_rd < nxt_wr; c++) begin
         @(negedge clk);
         if (m_valid) begin
            checks++;
            if (m_data !== DW'(exp_rd)) begin errors++; $display("FAIL drain_data got %h want %h", m_data, DW'(exp_rd)); end
            exp_rd++;
         end
         @(posedge clk); #1;
      end
      checks++; if (exp_rd != nxt_wr || level !== 5'd0) begin errors++; $display("FAIL drain_done got popped=%0d lvl=%0d want %0d 0", exp_rd, level, nxt_wr); end
      m_ready = 1'b0;
   endtask

   task automatic test_random_gaps();
      logic [31:0] wr_pat = 32'hB6D5_9A73;
      logic [31:0] rd_pat = 32'h5CA7_39E6;
      int nxt = 0;
      int exp = 0;
      for (int c = 0; c < 300 && exp < 20; c++) begin
         wr_en   = (nxt < 20) && wr_pat[c % 32];
         wr_data = DW'(nxt);
         m_ready = rd_pat[c % 32];
         @(negedge clk);
         if (m_valid && m_ready) begin
            checks++;
            if (m_data !== DW'(exp)) begin errors++; $display("FAIL gaps_data got %h want %h", m_data, DW'(exp)); end
            exp++;
         end
         if (wr_en && !full) nxt++;
         @(posedge clk); #1;
      end
      wr_en = 1'b0; m_ready = 1'b0;
      checks++; if (exp != 20) begin errors++; $display("FAIL gaps_count got %0d want 20", exp); end
      tick();
      checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL gaps_empty got v=%b lvl=%0d want 0 0", m_valid, level); end
   endtask

   task automatic test_flush();
      m_ready = 1'b0;
      wr_en = 1'b1; wr_data = 8'h33;
      tick();
      wr_data = 8'h44;
      @(negedge clk);
      checks++; if (mem_r_en !== 1'b1) begin errors++; $display("FAIL flush_issue got %b want 1", mem_r_en); end
      @(posedge clk); #1;
      wr_en = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL flush_clear got v=%b lvl=%0d want 0 0", m_valid, level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_ovf got %b want 1", overflow); end
      tick();
      checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL flush_discard got v=%b lvl=%0d want 0 0", m_valid, level); end
      wr_en = 1'b1; wr_data = 8'h5A;
      tick();
      wr_en = 1'b0;
      tick(); tick();
      checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin errors++; $display("FAIL flush_newdata got %b/%h want 1/5a", m_valid, m_data); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   task automatic test_clr_err();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_err got %b want 0", overflow); end
      wr_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wr_data = DW'(8'h80 + i);
         tick();
      end
      checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL clr_prefull got full=%b ovf=%b want 1 0", full, overflow); end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0; wr_en = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_setwins got %b want 1", overflow); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({full, almost_full, m_valid, overflow} !== 4'b0000) begin errors++; $display("FAIL areset_flags got %b want 0000", {full, almost_full, m_valid, overflow}); end
      checks++; if (level !== 5'd0 || m_data !== 8'h00) begin errors++; $display("FAIL areset_level got lvl=%0d d=%h want 0 00", level, m_data); end
      checks++; if ({mem_w_en, mem_r_en} !== 2'b00) begin errors++; $display("FAIL areset_en got %b want 00", {mem_w_en, mem_r_en}); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      wr_en = 1'b1; wr_data = 8'h77;
      tick();
      wr_en = 1'b0;
      tick(); tick();
      checks++; if (m_valid !== 1'b1 || m_data !== 8'h77) begin errors++; $display("FAIL areset_resume got %b/%h want 1/77", m_valid, m_data); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fill();
      test_stream();
      test_random_gaps();
      test_flush();
      test_clr_err();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
